icap_cfg_reg_reader: RTL and testbench

- Reads a single UltraScale+ configuration register (IDCODE, STAT, BOOTSTS, WBSTAR, …) back through the ICAPE3 port. It is the read-direction counterpart of the existing IPROG/reboot ICAP writer.
- Driven by a simple request/response handshake from the AXI-lite register block.
- Drives raw ICAPE3 pins. A top-level mux shares the single ICAP between this block and the reboot sequencer.

---
 rtl/icap_pkg.sv | 42 ++++
 rtl/icap_bitswap32.sv | 14 +
 rtl/icap_cfg_reg_reader.sv | 193 +++++++++++++++++++
 tb/tb_icap_cfg_reg_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icap_pkg.sv
// ICAPE3 command words, configuration register addresses and readback FSM states.
// Shared by the config-register reader and the IPROG reboot sequencer.
package icap_pkg;

  localparam logic [31:0] ICAP_DUMMY      = 32'hFFFF_FFFF;
  localparam logic [31:0] ICAP_SYNC       = 32'hAA99_5566;
  localparam logic [31:0] ICAP_NOOP       = 32'h2000_0000;
  localparam logic [31:0] ICAP_HDR_RD1    = 32'h2800_0001;
  localparam logic [31:0] ICAP_HDR_WR_CMD = 32'h3000_8001;
  localparam logic [31:0] ICAP_CMD_DESYNC = 32'h0000_000D;
  localparam logic [31:0] ICAP_CMD_IPROG  = 32'h0000_000F;

  localparam logic [4:0] CFG_REG_STAT    = 5'h07;
  localparam logic [4:0] CFG_REG_IDCODE  = 5'h0C;
  localparam logic [4:0] CFG_REG_WBSTAR  = 5'h10;
  localparam logic [4:0] CFG_REG_BOOTSTS = 5'h16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_AVAIL,
    ST_DUMMY,
    ST_SYNC,
    ST_NOOP0,
    ST_RDHDR,
    ST_NOOP1,
    ST_NOOP2,
    ST_GAP_R,
    ST_READ,
    ST_GAP_W,
    ST_DSYNC_HDR,
    ST_DSYNC_CMD,
    ST_NOOP3,
    ST_NOOP4,
    ST_RESP
  } icap_rd_state_t;

  // Type-1 read header for one word from register addr (address field is bits [17:13]).
  function automatic logic [31:0] icap_hdr_rd(input logic [4:0] addr);
    return ICAP_HDR_RD1 | {14'd0, addr, 13'd0};
  endfunction

endpackage

// File: rtl/icap_bitswap32.sv
// Per-byte bit reversal between logical word order and ICAPE3 pin order.
// Pure wiring, zero latency; the mapping is its own inverse so it serves both I and O.
module icap_bitswap32 (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar k = 0; k < 4; k++) begin : g_byte
    for (genvar j = 0; j < 8; j++) begin : g_bit
      assign dout[8*k+j] = din[8*k+7-j];
    end
  end

endmodule

// File: rtl/icap_cfg_reg_reader.sv
// Reads one configuration register through ICAPE3: sync, Type-1 read, capture, desync.
// One request in flight; req_ready drops until the response is accepted via rsp_ready.
module icap_cfg_reg_reader
  import icap_pkg::*;
#(
  parameter int RD_LAT        = 8,
  parameter int AVAIL_TIMEOUT = 1024,
  parameter int GAP_CYCLES    = 2
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  input  logic        icap_avail,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o
);

  localparam int CNT_MAX0 = (AVAIL_TIMEOUT > RD_LAT) ? AVAIL_TIMEOUT : RD_LAT;
  localparam int CNT_MAX  = (CNT_MAX0 > GAP_CYCLES) ? CNT_MAX0 : GAP_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(AVAIL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  icap_rd_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       addr;
  logic [31:0]      tx_word;
  logic [31:0]      rx_word;

  // tx_word is held in logical order; the swap is wiring only, so icap_i stays register-driven.
  icap_bitswap32 u_swap_i (
    .din  (tx_word),
    .dout (icap_i)
  );

  icap_bitswap32 u_swap_o (
    .din  (icap_o),
    .dout (rx_word)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      addr       <= '0;
      tx_word    <= ICAP_DUMMY;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            state     <= ST_WAIT_AVAIL;
            addr      <= req_addr;
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
          end
        end
        ST_WAIT_AVAIL: begin
          if (icap_avail) begin
            state     <= ST_DUMMY;
            icap_csib <= 1'b0;
            tx_word   <= ICAP_DUMMY;
            cnt       <= '0;
          end else if (cnt == TO_LAST) begin
            // Nothing reached the ICAP yet, so no desync is owed.
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DUMMY: begin
          state   <= ST_SYNC;
          tx_word <= ICAP_SYNC;
        end
        ST_SYNC: begin
          state   <= ST_NOOP0;
          tx_word <= ICAP_NOOP;
        end
        ST_NOOP0: begin
          state   <= ST_RDHDR;
          tx_word <= icap_hdr_rd(addr);
        end
        ST_RDHDR: begin
          state   <= ST_NOOP1;
          tx_word <= ICAP_NOOP;
        end
        ST_NOOP1: begin
          state   <= ST_NOOP2;
          tx_word <= ICAP_NOOP;
        end
        ST_NOOP2: begin
          // Deselect and flip direction on the same edge: ICAP sees CSIB high with the new RDWRB.
          state      <= ST_GAP_R;
          icap_csib  <= 1'b1;
          icap_rdwrb <= 1'b1;
          tx_word    <= ICAP_DUMMY;
          cnt        <= '0;
        end
        ST_GAP_R: begin
          if (cnt == GAP_LAST) begin
            state     <= ST_READ;
            icap_csib <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_READ: begin
          if (cnt == RD_LAST) begin
            state      <= ST_GAP_W;
            rsp_data   <= rx_word;
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP_W: begin
          if (cnt == GAP_LAST) begin
            state     <= ST_DSYNC_HDR;
            icap_csib <= 1'b0;
            tx_word   <= ICAP_HDR_WR_CMD;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DSYNC_HDR: begin
          state   <= ST_DSYNC_CMD;
          tx_word <= ICAP_CMD_DESYNC;
        end
        ST_DSYNC_CMD: begin
          state   <= ST_NOOP3;
          tx_word <= ICAP_NOOP;
        end
        ST_NOOP3: begin
          state   <= ST_NOOP4;
          tx_word <= ICAP_NOOP;
        end
        ST_NOOP4: begin
          state     <= ST_RESP;
          icap_csib <= 1'b1;
          tx_word   <= ICAP_DUMMY;
          rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          icap_csib  <= 1'b1;
          icap_rdwrb <= 1'b0;
          tx_word    <= ICAP_DUMMY;
          rsp_valid  <= 1'b0;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icap_cfg_reg_reader.sv
// Directed plus randomized readback bench with a behavioural ICAPE3 model and stream scoreboard.
module tb_icap_cfg_reg_reader;

  localparam int RD_LAT        = 8;
  localparam int AVAIL_TIMEOUT = 1024;
  localparam int GAP_CYCLES    = 2;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic        req_valid, req_ready;
  logic [4:0]  req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, busy;
  logic        icap_avail, icap_csib, icap_rdwrb;
  logic [31:0] icap_i, icap_o;

  always #5 axi_aclk = ~axi_aclk;

  icap_cfg_reg_reader #(
    .RD_LAT        (RD_LAT),
    .AVAIL_TIMEOUT (AVAIL_TIMEOUT),
    .GAP_CYCLES    (GAP_CYCLES)
  ) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .icap_avail  (icap_avail),
    .icap_csib   (icap_csib),
    .icap_rdwrb  (icap_rdwrb),
    .icap_i      (icap_i),
    .icap_o      (icap_o)
  );

  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Logical bit i sits at pin (byte*8 + 7 - bit-in-byte).
  function automatic logic [31:0] rev8(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[(i / 8) * 8 + 7 - (i % 8)] = w[i];
    return r;
  endfunction

  // ICAPE3 model: register file answered after a Type-1 read header is seen.
  logic [31:0] regs [32];
  logic [31:0] obs_q [$];
  logic [31:0] raw_q [$];
  logic [31:0] w;
  logic [4:0]  model_addr;
  logic        raw_override = 1'b0;
  logic [31:0] raw_val = 32'h0;
  logic        prev_rdwrb = 1'b0;
  int          csib_low_cnt = 0;
  int          read_cycles = 0;

  always @(negedge axi_aclk) begin
    if (icap_rdwrb !== prev_rdwrb) check("rdwrb_change_needs_csib_high", 32'(icap_csib), 32'd1);
    prev_rdwrb = icap_rdwrb;
    if (busy) check("req_ready_low_while_busy", 32'(req_ready), 32'd0);
    if (!icap_csib) begin
      csib_low_cnt++;
      if (!icap_rdwrb) begin
        w = rev8(icap_i);
        obs_q.push_back(w);
        raw_q.push_back(icap_i);
        if (w == 32'hFFFF_FFFF) icap_o = 32'hDEAD_BEEF;
        if ((w & 32'hFFFC_1FFF) == 32'h2800_0001) begin
          model_addr = w[17:13];
          icap_o = raw_override ? raw_val : rev8(regs[model_addr]);
        end
      end else begin
        read_cycles++;
      end
    end
  end

  logic [31:0] d, d0;
  logic        e;
  int          lat;
  logic [4:0]  a;
  int          dly, rc0, b;

  task automatic issue_req(input logic [4:0] addr_in);
    int bud = 0;
    req_addr  = addr_in;
    req_valid = 1'b1;
    while (!req_ready && bud < 2000) begin
      @(negedge axi_aclk);
      bud++;
    end
    check("req_accepted_in_budget", 32'(req_ready), 32'd1);
    @(negedge axi_aclk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] dat, output logic err, output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 5000) begin
      @(negedge axi_aclk);
      cycles++;
    end
    check("rsp_in_budget", 32'(rsp_valid), 32'd1);
    dat = rsp_data;
    err = rsp_err;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge axi_aclk);
    rsp_ready = 1'b0;
  endtask

  task automatic check_stream(input logic [4:0] addr_in);
    logic [31:0] exp_q [$];
    exp_q = '{32'hFFFF_FFFF, 32'hAA99_5566, 32'h2000_0000,
              32'h2800_0001 | (32'(addr_in) << 13),
              32'h2000_0000, 32'h2000_0000, 32'h3000_8001, 32'h0000_000D,
              32'h2000_0000, 32'h2000_0000};
    check("stream_len", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("stream_word%0d", i), (i < obs_q.size()) ? obs_q[i] : 32'h0BAD_0BAD, exp_q[i]);
  endtask

  initial begin
    req_valid  = 1'b0;
    req_addr   = 5'd0;
    rsp_ready  = 1'b0;
    icap_avail = 1'b1;
    icap_o     = 32'hDEAD_BEEF;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[12] = 32'h04A6_3093;

    repeat (3) @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    check("rst_csib", 32'(icap_csib), 32'd1);
    check("rst_rdwrb", 32'(icap_rdwrb), 32'd0);
    check("rst_icap_i", icap_i, 32'hFFFF_FFFF);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // IDCODE read with known value
    obs_q.delete(); raw_q.delete(); read_cycles = 0;
    issue_req(5'h0C);
    wait_rsp(d, e, lat);
    check("idcode_data", d, 32'h04A6_3093);
    check("idcode_err", 32'(e), 32'd0);
    check_stream(5'h0C);
    check("idcode_read_cycles", 32'(read_cycles), 32'(RD_LAT));
    check("sync_raw_pins", (raw_q.size() > 1) ? raw_q[1] : 32'h0, 32'h5599_AA66);
    ack_rsp();
    check("idcode_rsp_cleared", 32'(rsp_valid), 32'd0);
    check("idcode_idle", 32'(busy), 32'd0);

    // Raw pin order on O
    raw_override = 1'b1; raw_val = 32'h0000_0001;
    issue_req(5'h16);
    wait_rsp(d, e, lat);
    check("bitorder_o", d, 32'h0000_0080);
    ack_rsp();
    raw_override = 1'b0;

    // AVAIL never rises
    icap_avail = 1'b0; csib_low_cnt = 0;
    issue_req(5'h10);
    wait_rsp(d, e, lat);
    check("timeout_latency", 32'(lat), 32'(AVAIL_TIMEOUT));
    check("timeout_err", 32'(e), 32'd1);
    check("timeout_data", d, 32'd0);
    check("timeout_csib_never_low", 32'(csib_low_cnt), 32'd0);
    ack_rsp();
    icap_avail = 1'b1;

    // Random addresses, values, AVAIL delays and mid-sequence AVAIL drops
    for (int n = 0; n < 100; n++) begin
      a = 5'($urandom_range(0, 31));
      regs[a] = $urandom;
      dly = $urandom_range(0, 4);
      if (dly > 0) icap_avail = 1'b0;
      obs_q.delete();
      issue_req(a);
      repeat (dly) @(negedge axi_aclk);
      icap_avail = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        repeat (3) @(negedge axi_aclk);
        icap_avail = 1'b0;
      end
      wait_rsp(d, e, lat);
      icap_avail = 1'b1;
      check("rand_data", d, regs[a]);
      check("rand_err", 32'(e), 32'd0);
      check_stream(a);
      repeat ($urandom_range(0, 3)) @(negedge axi_aclk);
      ack_rsp();
    end

    // Held response with a second request waiting
    obs_q.delete();
    d0 = regs[12];
    regs[7] = $urandom;
    issue_req(5'h0C);
    wait_rsp(d, e, lat);
    check("bp_first_data", d, d0);
    req_addr = 5'h07; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge axi_aclk);
      check("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data_stable", rsp_data, d0);
      check("bp_req_held_off", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge axi_aclk);
    rsp_ready = 1'b0;
    check("bp_not_yet_accepted", 32'(busy), 32'd0);
    check("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
    obs_q.delete();
    issue_req(5'h07);
    wait_rsp(d, e, lat);
    check("bp_stat_data", d, regs[7]);
    check_stream(5'h07);
    ack_rsp();

    // Reset in the middle of READ
    rc0 = read_cycles; b = 0;
    issue_req(5'h16);
    while (read_cycles < rc0 + 3 && b < 200) begin
      @(negedge axi_aclk);
      b++;
    end
    check("reached_read", 32'(read_cycles >= rc0 + 3), 32'd1);
    axi_aresetn = 1'b0;
    #1;
    check("midrst_csib", 32'(icap_csib), 32'd1);
    check("midrst_rdwrb", 32'(icap_rdwrb), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge axi_aclk);
    check("midrst_csib_held", 32'(icap_csib), 32'd1);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    obs_q.delete();
    issue_req(5'h0C);
    wait_rsp(d, e, lat);
    check("post_rst_data", d, regs[12]);
    check("post_rst_err", 32'(e), 32'd0);
    check_stream(5'h0C);
    ack_rsp();

    repeat (3) @(negedge axi_aclk);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
